// File: rtl/ap_unsi_div_16b_seq_pkg.sv
// Shared types and constants for the sequential unsigned restoring divider.
package ap_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;

  // Default operand width; the dividend is twice as wide.
  localparam int unsigned AP_DIV_DW = 8;

  // Iteration counter width for the default operand width.
  localparam int unsigned AP_DIV_CNT_W = $clog2(AP_DIV_DW + 1);

  // Quotient reported when the true quotient cannot be represented.
  localparam logic [AP_DIV_DW-1:0] AP_DIV_QUO_OVF = '1;

  // Counter width for an arbitrary operand width.
  function automatic int unsigned div_cnt_w(input int unsigned dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/ap_unsi_div_16b_seq_div_step.sv
// One combinational restoring-division iteration: shift the next dividend
// bit into the partial remainder and subtract the divisor if it fits.
module div_step
  import ap_div_pkg::*;
#(
  parameter int unsigned DW = AP_DIV_DW
) (
  input  logic [DW-1:0] r,
  input  logic          bit_in,
  input  logic [DW-1:0] dvs,
  output logic [DW-1:0] r_next,
  output logic          q_bit
);

  logic [DW:0] shifted;

  // The incoming remainder is always below dvs, so the shifted value is
  // below 2*dvs and either result fits back into DW bits.
  always_comb begin
    shifted = {r, bit_in};
    q_bit   = (shifted >= {1'b0, dvs});
    r_next  = q_bit ? (shifted[DW-1:0] - dvs) : shifted[DW-1:0];
  end

endmodule

// File: rtl/ap_unsi_div_16b_seq.sv
// Sequential unsigned restoring divider: 2*DW-bit dividend / DW-bit divisor.
// Valid/ready handshake on both sides, one division in flight at a time.
// Optional macro AP_DIV_TRUNC_EN skips the last TRUNC_BITS iterations
// (approximate quotient with its low TRUNC_BITS bits forced to zero).
module ap_unsi_div_16b_seq
  import ap_div_pkg::*;
#(
  parameter int unsigned DW         = AP_DIV_DW,
  parameter int unsigned TRUNC_BITS = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [2*DW-1:0] dvd,
  input  logic [DW-1:0] dvs,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] quo,
  output logic [DW-1:0] rem,
  output logic          ovf
);

`ifdef AP_DIV_TRUNC_EN
  localparam bit TRUNC_ON = 1'b1;
`else
  localparam bit TRUNC_ON = 1'b0;
`endif

  localparam int unsigned TB_LEGAL = (TRUNC_BITS < DW) ? TRUNC_BITS : DW - 1;
  localparam int unsigned SKIP     = TRUNC_ON ? TB_LEGAL : 0;
  localparam int unsigned N_ITER   = DW - SKIP;
  localparam int unsigned CNT_W    = div_cnt_w(DW);

  div_state_e state, state_nxt;

  // Partial remainder kept at DW bits: it stays below dvs between iterations.
  logic [DW-1:0]    r_reg;
  logic [DW-1:0]    q_reg;
  logic [DW-1:0]    dvs_reg;
  logic [CNT_W-1:0] cnt;
  logic             ovf_reg;

  logic             ovf_cond;
  logic             last_iter;
  logic [DW-1:0]    r_next;
  logic             q_bit;

  assign ovf_cond  = (dvd[2*DW-1:DW] >= dvs);
  assign last_iter = (cnt == CNT_W'(N_ITER - 1));

  div_step #(.DW(DW)) u_step (
    .r      (r_reg),
    .bit_in (q_reg[DW-1]),
    .dvs    (dvs_reg),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    unique case (state)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_vld) state_nxt = ovf_cond ? DONE : CALC;
      end
      CALC: begin
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        out_vld = 1'b1;
        if (out_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, iterate in CALC, hold in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg   <= '0;
      q_reg   <= '0;
      dvs_reg <= '0;
      cnt     <= '0;
      ovf_reg <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_vld) begin
            dvs_reg <= dvs;
            cnt     <= '0;
            if (ovf_cond) begin
              r_reg   <= '0;
              q_reg   <= '1;
              ovf_reg <= 1'b1;
            end else begin
              r_reg   <= dvd[2*DW-1:DW];
              q_reg   <= dvd[DW-1:0];
              ovf_reg <= 1'b0;
            end
          end
        end
        CALC: begin
          r_reg <= r_next;
          q_reg <= {q_reg[DW-2:0], q_bit};
          cnt   <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Results are presented only while out_vld is high, zero otherwise.
  // With skipped iterations the computed quotient bits sit in the low part
  // of q_reg and are moved up so the skipped positions read as zero.
  always_comb begin
    quo = '0;
    rem = '0;
    ovf = 1'b0;
    if (state == DONE) begin
      quo = ovf_reg ? '1 : (q_reg << SKIP);
      rem = r_reg;
      ovf = ovf_reg;
    end
  end

endmodule

// File: tb/tb_ap_unsi_div_16b_seq.sv
// Self-checking bench for ap_unsi_div_16b_seq: directed corner cases plus
// randomized operands compared against an arithmetic reference model.
module tb_ap_unsi_div_16b_seq;

  localparam int unsigned DW = 8;
`ifdef AP_DIV_TRUNC_EN
  localparam int unsigned SK = 2;
`else
  localparam int unsigned SK = 0;
`endif

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        in_vld  = 1'b0;
  logic        out_rdy = 1'b0;
  logic [15:0] dvd     = '0;
  logic [7:0]  dvs     = '0;
  logic        in_rdy;
  logic        out_vld;
  logic        ovf;
  logic [7:0]  quo;
  logic [7:0]  rem;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  ap_unsi_div_16b_seq #(
    .DW         (DW),
    .TRUNC_BITS (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .dvd     (dvd),
    .dvs     (dvs),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .quo     (quo),
    .rem     (rem),
    .ovf     (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer division of the (possibly truncated) dividend.
  function automatic void ref_div(input logic [15:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output bit o);
    int unsigned hi, d;
    hi = a / 256;
    if (hi >= b) begin
      o = 1'b1;
      q = 8'hFF;
      r = 8'h00;
    end else begin
      o = 1'b0;
      d = a >> SK;
      q = 8'(((d / b) << SK) & 32'hFF);
      r = 8'(d % b);
    end
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input int unsigned stall);
    logic [7:0]  eq, er;
    bit          eo;
    int unsigned lat, wait_n;
    bit          seen;
    ref_div(a, b, eq, er, eo);
    @(negedge clk);
    wait_n = 0;
    while (!in_rdy && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    check("in_rdy_wait", 32'(in_rdy), 32'd1);
    dvd     = a;
    dvs     = b;
    in_vld  = 1'b1;
    out_rdy = (stall == 0);
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    dvd    = 16'($urandom);
    dvs    = 8'($urandom);
    lat    = 0;
    seen   = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      seen = out_vld;
    end
    check("latency", lat, eo ? 32'd1 : 32'(DW - SK + 1));
    check("quo", 32'(quo), 32'(eq));
    check("rem", 32'(rem), 32'(er));
    check("ovf", 32'(ovf), 32'(eo));
    for (int unsigned i = 0; i < stall; i++) begin
      in_vld = 1'b1;
      dvd    = 16'($urandom);
      dvs    = 8'($urandom);
      @(negedge clk);
      check("bp_out_vld", 32'(out_vld), 32'd1);
      check("bp_quo", 32'(quo), 32'(eq));
      check("bp_rem", 32'(rem), 32'(er));
      check("bp_in_rdy", 32'(in_rdy), 32'd0);
    end
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    @(negedge clk);
    check("out_vld_drop", 32'(out_vld), 32'd0);
    check("in_rdy_back", 32'(in_rdy), 32'd1);
  endtask

  initial begin
    int unsigned vld_seen;
    logic [15:0] ra;
    logic [7:0]  rb;
    int unsigned rq, rr, mode;

    // Reset values while rst_n is held low.
    #12;
    check("rst_in_rdy", 32'(in_rdy), 32'd1);
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_quo", 32'(quo), 32'd0);
    check("rst_rem", 32'(rem), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    run_op(16'h0E2A, 8'd29, 0);
    run_op(16'h1234, 8'h00, 0);
    run_op(16'h1F00, 8'h1F, 0);
    run_op(16'hFEFF, 8'hFF, 0);
    run_op(16'h0000, 8'd5, 0);
    run_op(16'h00AB, 8'd1, 0);
    run_op(16'h00FF, 8'd1, 0);
    run_op(16'd1000, 8'd9, 5);
    run_op(16'h1234, 8'h00, 3);

    // Reset in the middle of an iteration sequence.
    @(negedge clk);
    dvd    = 16'd3626;
    dvs    = 8'd29;
    in_vld = 1'b1;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_rdy", 32'(in_rdy), 32'd1);
    check("midrst_out_vld", 32'(out_vld), 32'd0);
    check("midrst_quo", 32'(quo), 32'd0);
    check("midrst_rem", 32'(rem), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    vld_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_vld) vld_seen++;
    end
    check("midrst_no_pulse", vld_seen, 32'd0);
    run_op(16'd100, 8'd7, 0);

    // Randomized operands, biased toward non-overflowing divisions.
    for (int n = 0; n < 1500; n++) begin
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        ra = 16'($urandom);
        rb = 8'($urandom);
      end else if (mode == 1) begin
        ra = 16'($urandom);
        rb = 8'h00;
      end else begin
        rb = 8'($urandom_range(1, 255));
        rq = $urandom_range(0, 255);
        rr = $urandom_range(0, rb - 1);
        ra = 16'(rq * rb + rr);
      end
      run_op(ra, rb, ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
